// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
// Optional signed build: define MULT_ARB_SIGNED_EN.
package mult_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 4;
  localparam int MAX_REQ     = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set valid at or after ptr, wrapping within n requesters.
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0]         ptr,
    input int                 n
  );
    pick_t p;
    int    k;
    p = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        k = int'(ptr) + i;
        if (k >= n) k = k - n;
        if (valid[k]) begin
          p.found = 1'b1;
          p.idx   = 3'(k);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mult_core.sv
// Combinational array multiplier, 2*WIDTH result.
// MULT_ARB_SIGNED_EN selects two's-complement operands.
module mult_core
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;

`ifdef MULT_ARB_SIGNED_EN
  // Sign-extending both operands makes the mod-2^PW sum exact.
  localparam int ROWS = PW;
  logic [PW-1:0]   aa;
  logic [ROWS-1:0] mr;
  assign aa = {{WIDTH{a[WIDTH-1]}}, a};
  assign mr = {{WIDTH{b[WIDTH-1]}}, b};
`else
  localparam int ROWS = WIDTH;
  logic [PW-1:0]   aa;
  logic [ROWS-1:0] mr;
  assign aa = {{WIDTH{1'b0}}, a};
  assign mr = b;
`endif

  logic [PW-1:0] pp;
  logic [PW-1:0] acc;

  always_comb begin
    acc = '0;
    pp  = '0;
    for (int i = 0; i < ROWS; i++) begin
      pp  = mr[i] ? aa : '0;
      acc = acc + (pp << i);
    end
    product = acc;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier among NUM_REQ requesters.
// Optional signed build: define MULT_ARB_SIGNED_EN.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int WIDTH   = WIDTH_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_product,
  input  logic                     rsp_ready
);

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     grant;
  logic [ID_W-1:0]     ptr_next;
  pick_t               pick;
  logic                accept_ok;
  logic                xfer;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [2*WIDTH-1:0]  product;

  // A drain and a new accept may share a cycle.
  assign accept_ok = rst_n &&
                     ((state == IDLE) || (rsp_valid && rsp_ready));

  assign pick  = rr_pick(MAX_REQ'(req_valid), 3'(ptr), NUM_REQ);
  assign grant = pick.idx[ID_W-1:0];
  assign xfer  = accept_ok && pick.found;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant] = 1'b1;
  end

  assign op_a = req_a[grant*WIDTH +: WIDTH];
  assign op_b = req_b[grant*WIDTH +: WIDTH];

  assign ptr_next = (grant == ID_W'(NUM_REQ - 1)) ?
                    '0 : grant + ID_W'(1);

  mult_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a       (op_a),
    .b       (op_b),
    .product (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else if (xfer) begin
      state       <= RESP;
      ptr         <= ptr_next;
      rsp_valid   <= 1'b1;
      rsp_id      <= grant;
      rsp_product <= product;
    end else if (state == RESP && rsp_ready) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter (NUM_REQ=4, WIDTH=4).
// Builds with or without MULT_ARB_SIGNED_EN.
module tb_mult_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [2*W-1:0] rsp_product;
  logic           rsp_ready;

  int checks = 0;
  int errors = 0;
  int g;

  mult_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_ready   (rsp_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mul(input logic [3:0] a,
                                         input logic [3:0] b);
    int x;
    int y;
`ifdef MULT_ARB_SIGNED_EN
    x = $signed(a);
    y = $signed(b);
`else
    x = int'(a);
    y = int'(b);
`endif
    return 8'(x * y);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a,
                        input logic [3:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 4'(i + 5), 4'(i + 9));

    // Reset with all requesters asking: nothing may be granted.
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_product", rsp_product, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("first_ready", req_ready, 4'b0001);
    tick();
    chk("first_id", rsp_id, 0);
    chk("first_product", rsp_product, ref_mul(4'd5, 4'd9));
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    chk("first_drain", rsp_valid, 0);

    // Single request on requester 2.
    set_op(2, 4'hF, 4'hF);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", req_ready, 4'b0100);
    tick();
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 2);
`ifdef MULT_ARB_SIGNED_EN
    chk("single_product", rsp_product, 8'h01);
`else
    chk("single_product", rsp_product, 8'hE1);
`endif
    req_valid = '0;
    tick();
    chk("single_drain", rsp_valid, 0);

    // Fairness: everyone valid, consumer always ready; ptr is 3 here.
    set_op(2, 4'd7, 4'd11);
    req_valid = 4'hF;
    g = 3;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fair_ready", req_ready, 32'(1) << g);
      tick();
      chk("fair_valid", rsp_valid, 1);
      chk("fair_id", rsp_id, g);
      chk("fair_product", rsp_product, ref_mul(4'(g + 5), 4'(g + 9)));
      g = (g + 1) % N;
    end
    req_valid = '0;
    tick();
    chk("fair_drain", rsp_valid, 0);

    // Backpressure: ptr is 1, requester 0 wins then stalls the pipe.
    rsp_ready = 1'b0;
    set_op(0, 4'd3, 4'd4);
    req_valid = 4'b0001;
    #1;
    chk("bp_ready0", req_ready, 4'b0001);
    tick();
    set_op(1, 4'd9, 4'd7);
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready_hold", req_ready, 0);
      chk("bp_valid_hold", rsp_valid, 1);
      chk("bp_id_hold", rsp_id, 0);
      chk("bp_product_hold", rsp_product, ref_mul(4'd3, 4'd4));
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready1", req_ready, 4'b0010);
    tick();
    chk("bp_id1", rsp_id, 1);
    chk("bp_product1", rsp_product, ref_mul(4'd9, 4'd7));

    // Sparse wrap: ptr is 2.
    set_op(3, 4'd2, 4'd3);
    req_valid = 4'b1000;
    #1;
    chk("wrap_ready3", req_ready, 4'b1000);
    tick();
    chk("wrap_id3", rsp_id, 3);
    chk("wrap_product3", rsp_product, ref_mul(4'd2, 4'd3));
    req_valid = 4'b0010;
    #1;
    chk("wrap_ready1", req_ready, 4'b0010);
    tick();
    chk("wrap_id1", rsp_id, 1);
    set_op(2, 4'd7, 4'd11);
    req_valid = 4'b0101;
    #1;
    chk("wrap_ready2", req_ready, 4'b0100);
    tick();
    chk("wrap_id2", rsp_id, 2);
    chk("wrap_product2", rsp_product, ref_mul(4'd7, 4'd11));
    req_valid = '0;
    tick();
    chk("wrap_drain", rsp_valid, 0);

    // Every operand pair through requester 0, one per cycle.
    req_valid = 4'b0001;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        set_op(0, 4'(a), 4'(b));
        tick();
        chk("exh_product", rsp_product, ref_mul(4'(a), 4'(b)));
      end
    end
    chk("exh_id", rsp_id, 0);
    req_valid = '0;
    tick();

    // Reset while a response is held; ptr is 1 beforehand.
    rsp_ready = 1'b0;
    set_op(0, 4'd5, 4'd5);
    req_valid = 4'b0001;
    tick();
    chk("mid_valid_pre", rsp_valid, 1);
    req_valid = 4'b0011;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", rsp_valid, 0);
    chk("mid_product", rsp_product, 0);
    chk("mid_ready", req_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_ready_rel", req_ready, 4'b0001);
    tick();
    chk("mid_id", rsp_id, 0);
    chk("mid_product_rel", rsp_product, ref_mul(4'd5, 4'd5));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
